// File: rtl/dcache_pkg.sv
// Shared types for the data-cache controller: FSM state encoding and policy codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcache_pkg;

  typedef enum logic [2:0] {
    START       = 3'd0,
    WRITE_BACK  = 3'd1,
    LOAD        = 3'd2,
    REFILL_DONE = 3'd3,
    MEM_WRITE   = 3'd4
  } state_t;

  localparam int POLICY_WB = 0;
  localparam int POLICY_WT = 1;

endpackage

// File: rtl/dcache_ctrl_fsm_if.sv
// Bundle of pipeline, cache-array and memory-port signals around the cache controller.
// Latency: n/a (wiring only).
// Backpressure: stall toward the pipeline, mem_req held until mem_ack from memory.
interface dcache_ctrl_fsm_if #(
  parameter int IDX_W = 2
);
  logic             read;
  logic             write;
  logic             hit;
  logic             dirty;
  logic             mem_ack;
  logic             stall;
  logic             cache_we;
  logic             fill_we;
  logic             set_valid;
  logic             set_dirty;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic [IDX_W-1:0] word_idx;

  // Controller side
  modport master (
    input  read, write, hit, dirty, mem_ack,
    output stall, cache_we, fill_we, set_valid, set_dirty,
    output mem_req, mem_we, addr_sel, word_idx
  );

  // Pipeline / arrays / memory side
  modport slave (
    output read, write, hit, dirty, mem_ack,
    input  stall, cache_we, fill_we, set_valid, set_dirty,
    input  mem_req, mem_we, addr_sel, word_idx
  );
endinterface

// File: rtl/dcache_word_ctr.sv
// Burst word counter: clears on request, advances on each accepted word, flags the last word.
// Latency: idx updates one clock after clr/inc; last is combinational from idx.
// Backpressure: none; only moves when inc (a memory ack) is seen.
module dcache_word_ctr #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  assign last = (idx == IDX_W'(WORDS_PER_BLOCK - 1));

  // Word index: clear has priority, wrap to zero after the last word of the line
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_ctrl_fsm.sv
// Data-cache controller: hit/miss/dirty decisions, line write-back and refill bursts, write-through.
// Latency: hits complete in the request cycle; misses take one cycle per acked word plus a valid cycle.
// Backpressure: stall held while any memory work is pending; mem_req held stable until mem_ack.
module dcache_ctrl_fsm
  import dcache_pkg::*;
#(
  parameter int  WORDS_PER_BLOCK = 4,
  parameter int  WRITE_THROUGH   = POLICY_WB,
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input logic              CLK,
  input logic              RST,
  dcache_ctrl_fsm_if.master bus
);

  localparam bit WT = (WRITE_THROUGH == POLICY_WT);

  state_t           state;
  state_t           state_nxt;
  logic             ctr_clr;
  logic             ctr_inc;
  logic             ctr_last;
  logic [IDX_W-1:0] ctr_idx;

  logic stall, cache_we, fill_we, set_valid, set_dirty, mem_req, mem_we, addr_sel;

  dcache_word_ctr #(
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .IDX_W           (IDX_W)
  ) u_word_ctr (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (ctr_clr),
    .inc  (ctr_inc),
    .idx  (ctr_idx),
    .last (ctr_last)
  );

  // State register; reset abandons any burst in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= START;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs; hit/dirty only matter in START, read beats write
  always_comb begin
    state_nxt = state;
    ctr_clr   = 1'b0;
    ctr_inc   = 1'b0;
    stall     = 1'b0;
    cache_we  = 1'b0;
    fill_we   = 1'b0;
    set_valid = 1'b0;
    set_dirty = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    unique case (state)
      START: begin
        // Counter is parked at zero here so every burst starts at word 0
        ctr_clr = 1'b1;
        if (bus.read) begin
          if (!bus.hit) begin
            stall     = 1'b1;
            state_nxt = (bus.dirty && !WT) ? WRITE_BACK : LOAD;
          end
        end else if (bus.write) begin
          if (bus.hit) begin
            cache_we = 1'b1;
            if (WT) begin
              stall     = 1'b1;
              state_nxt = MEM_WRITE;
            end else begin
              set_dirty = 1'b1;
            end
          end else begin
            stall = 1'b1;
            if (WT) begin
              state_nxt = MEM_WRITE;
            end else begin
              state_nxt = bus.dirty ? WRITE_BACK : LOAD;
            end
          end
        end
      end
      WRITE_BACK: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        ctr_inc  = bus.mem_ack;
        if (bus.mem_ack && ctr_last) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        fill_we = bus.mem_ack;
        ctr_inc = bus.mem_ack;
        if (bus.mem_ack && ctr_last) begin
          state_nxt = REFILL_DONE;
        end
      end
      REFILL_DONE: begin
        stall     = 1'b1;
        set_valid = 1'b1;
        state_nxt = START;
      end
      MEM_WRITE: begin
        // Release the pipeline in the ack cycle so the store retires at that edge
        stall   = !bus.mem_ack;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (bus.mem_ack) begin
          state_nxt = START;
        end
      end
      default: begin
        state_nxt = START;
      end
    endcase
  end

  assign bus.stall     = stall;
  assign bus.cache_we  = cache_we;
  assign bus.fill_we   = fill_we;
  assign bus.set_valid = set_valid;
  assign bus.set_dirty = set_dirty;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.addr_sel  = addr_sel;
  assign bus.word_idx  = ctr_idx;

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Bench for the data-cache controller: one write-back and one write-through instance.
// Latency: n/a.
// Backpressure: memory responder acks a configurable number of cycles after mem_req.
module tb_dcache_ctrl_fsm;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dcache_ctrl_fsm_if #(.IDX_W(2)) if0 ();
  dcache_ctrl_fsm_if #(.IDX_W(2)) if1 ();

  dcache_ctrl_fsm #(.WORDS_PER_BLOCK(N), .WRITE_THROUGH(0)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (if0.master)
  );
  dcache_ctrl_fsm #(.WORDS_PER_BLOCK(N), .WRITE_THROUGH(1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (if1.master)
  );

  // Pipeline/array inputs, one bit per instance (0 = WB, 1 = WT)
  logic [1:0] rd, wr, ht, dt, resp_ack, stray, resp_en;
  wire  [1:0] ack = resp_ack | stray;
  int         delay [2];

  assign if0.read = rd[0];  assign if0.write = wr[0];  assign if0.hit = ht[0];
  assign if0.dirty = dt[0]; assign if0.mem_ack = ack[0];
  assign if1.read = rd[1];  assign if1.write = wr[1];  assign if1.hit = ht[1];
  assign if1.dirty = dt[1]; assign if1.mem_ack = ack[1];

  // Output vector: {stall,cache_we,fill_we,set_valid,set_dirty,mem_req,mem_we,addr_sel,word_idx}
  wire [9:0] act0 = {if0.stall, if0.cache_we, if0.fill_we, if0.set_valid, if0.set_dirty,
                     if0.mem_req, if0.mem_we, if0.addr_sel, if0.word_idx};
  wire [9:0] act1 = {if1.stall, if1.cache_we, if1.fill_we, if1.set_valid, if1.set_dirty,
                     if1.mem_req, if1.mem_we, if1.addr_sel, if1.word_idx};

  function automatic logic [9:0] get_act(int k);
    return (k == 0) ? act0 : act1;
  endfunction

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actv, input logic [31:0] expv);
    checks++;
    if (actv !== expv) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actv, expv);
    end
  endtask

  // Work-remaining model: words left to write back, words left to fill, pending valid/store
  int wb_left   [2];
  int fill_left [2];
  bit valid_pend[2];
  bit wt_pend   [2];

  function automatic bit model_idle(int k);
    return wb_left[k] == 0 && fill_left[k] == 0 && !valid_pend[k] && !wt_pend[k];
  endfunction

  function automatic logic [9:0] model_out(int k);
    bit         wt = (k == 1);
    logic       s = 0, cw = 0, fw = 0, sv = 0, sd = 0, mr = 0, mw = 0, as = 0;
    logic [1:0] wi = 2'd0;
    if (wb_left[k] > 0) begin
      s = 1; mr = 1; mw = 1; as = 1; wi = 2'(N - wb_left[k]);
    end else if (fill_left[k] > 0) begin
      s = 1; mr = 1; fw = ack[k]; wi = 2'(N - fill_left[k]);
    end else if (valid_pend[k]) begin
      s = 1; sv = 1;
    end else if (wt_pend[k]) begin
      mr = 1; mw = 1; s = !ack[k];
    end else if (rd[k]) begin
      s = !ht[k];
    end else if (wr[k]) begin
      if (ht[k]) begin
        cw = 1;
        if (wt) s = 1; else sd = 1;
      end else begin
        s = 1;
      end
    end
    return {s, cw, fw, sv, sd, mr, mw, as, wi};
  endfunction

  task automatic model_step(int k);
    bit wt = (k == 1);
    if (wb_left[k] > 0) begin
      if (ack[k]) wb_left[k]--;
    end else if (fill_left[k] > 0) begin
      if (ack[k]) begin
        fill_left[k]--;
        if (fill_left[k] == 0) valid_pend[k] = 1;
      end
    end else if (valid_pend[k]) begin
      valid_pend[k] = 0;
    end else if (wt_pend[k]) begin
      if (ack[k]) wt_pend[k] = 0;
    end else if ((rd[k] && !ht[k]) || (!rd[k] && wr[k] && !ht[k] && !wt)) begin
      if (dt[k] && !wt) wb_left[k] = N;
      fill_left[k] = N;
    end else if (!rd[k] && wr[k] && wt) begin
      wt_pend[k] = 1;
    end
  endtask

  // Model advance on every clock, cleared by reset
  initial begin
    for (int k = 0; k < 2; k++) begin
      wb_left[k] = 0; fill_left[k] = 0; valid_pend[k] = 0; wt_pend[k] = 0;
    end
    forever begin
      @(posedge CLK or negedge RST);
      for (int k = 0; k < 2; k++) begin
        if (!RST) begin
          wb_left[k] = 0; fill_left[k] = 0; valid_pend[k] = 0; wt_pend[k] = 0;
        end else begin
          model_step(k);
        end
      end
    end
  end

  // Event monitors
  int fill_q[$];
  int sv_cnt[2], wb_acks[2], fill_cnt[2];
  int sd_cnt1, mw_stall, mw_ack;

  task automatic clear_mon();
    fill_q.delete();
    for (int k = 0; k < 2; k++) begin
      sv_cnt[k] = 0; wb_acks[k] = 0; fill_cnt[k] = 0;
    end
    sd_cnt1 = 0; mw_stall = 0; mw_ack = 0;
  endtask

  // Per-cycle compare against the model, then event bookkeeping
  initial begin
    clear_mon();
    forever begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        logic [9:0] a;
        a = get_act(k);
        check($sformatf("cycle_inst%0d", k), 32'(a), 32'(model_out(k)));
        if (a[6]) sv_cnt[k]++;
        if (a[7]) fill_cnt[k]++;
        if (a[4] && a[3] && a[2] && ack[k]) wb_acks[k]++;
      end
      if (act0[7]) fill_q.push_back(int'(act0[1:0]));
      if (act1[5]) sd_cnt1++;
      if (act1[4] && act1[3] && !act1[2]) begin
        if (act1[9]) mw_stall++;
        else if (ack[1]) mw_ack++;
      end
    end
  end

  // Memory responder: ack delay[k] cycles after mem_req is seen, per word
  initial begin
    int cnt[2];
    resp_ack = 2'b00;
    cnt[0] = 0; cnt[1] = 0;
    forever begin
      @(posedge CLK);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!RST || !resp_en[k] || !get_act(k)[4]) begin
          resp_ack[k] = 1'b0; cnt[k] = 0;
        end else if (cnt[k] >= delay[k]) begin
          resp_ack[k] = 1'b1; cnt[k] = 0;
        end else begin
          resp_ack[k] = 1'b0; cnt[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    rd = 2'b00; wr = 2'b00; ht = 2'b00; dt = 2'b00;
  endtask

  task automatic wait_idle(int k);
    for (int i = 0; i < 300; i++) begin
      if (model_idle(k)) break;
      tick();
    end
    check($sformatf("burst_done_inst%0d", k), 32'(model_idle(k)), 32'd1);
  endtask

  initial begin
    bit found;
    RST = 1'b0;
    idle_in();
    stray = 2'b00; resp_en = 2'b00;
    delay[0] = 3; delay[1] = 5;

    // Reset state
    repeat (2) tick();
    @(negedge CLK);
    check("reset_outs_wb", 32'(act0), 32'd0);
    check("reset_outs_wt", 32'(act1), 32'd0);
    tick();
    RST = 1'b1;
    tick();

    // Read hit, write-back
    rd[0] = 1; ht[0] = 1;
    @(negedge CLK);
    check("rdhit_stall", 32'(act0[9]), 32'd0);
    check("rdhit_memreq", 32'(act0[4]), 32'd0);
    tick();
    @(negedge CLK);
    check("rdhit_stay", 32'(act0), 32'd0);
    tick();
    idle_in();
    tick();

    // Clean read miss, 3-cycle ack delay
    clear_mon();
    resp_en[0] = 1; delay[0] = 3;
    rd[0] = 1; ht[0] = 0; dt[0] = 0;
    @(negedge CLK);
    check("rdmiss_stall", 32'(act0[9]), 32'd1);
    tick();
    ht[0] = 1;
    wait_idle(0);
    @(negedge CLK);
    check("rdmiss_rehit_stall", 32'(act0[9]), 32'd0);
    check("rdmiss_fill_count", 32'(fill_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < fill_q.size()) check($sformatf("rdmiss_fill_idx%0d", i), 32'(fill_q[i]), 32'(i));
    check("rdmiss_set_valid", 32'(sv_cnt[0]), 32'd1);
    tick();
    idle_in();
    tick();

    // Dirty write miss, write-back + allocate
    clear_mon();
    wr[0] = 1; ht[0] = 0; dt[0] = 1;
    @(negedge CLK);
    check("wrmiss_outs", 32'(act0), 32'h200);
    tick();
    ht[0] = 1; dt[0] = 0;
    @(negedge CLK);
    check("wrmiss_wb_we_sel", 32'({act0[4], act0[3], act0[2]}), 32'h7);
    wait_idle(0);
    @(negedge CLK);
    check("wrmiss_final", 32'({act0[9], act0[8], act0[5]}), 32'h3);
    check("wrmiss_wb_acks", 32'(wb_acks[0]), 32'd4);
    check("wrmiss_fill_cnt", 32'(fill_cnt[0]), 32'd4);
    check("wrmiss_set_valid", 32'(sv_cnt[0]), 32'd1);
    tick();
    idle_in();
    tick();

    // Read and write together: read priority, clean miss then re-hit without store
    clear_mon();
    rd[0] = 1; wr[0] = 1; ht[0] = 0; dt[0] = 0;
    tick();
    ht[0] = 1;
    @(negedge CLK);
    check("rdwr_load", 32'({act0[4], act0[3], act0[2]}), 32'h4);
    wait_idle(0);
    @(negedge CLK);
    check("rdwr_no_store", 32'(act0[8]), 32'd0);
    check("rdwr_no_wb", 32'(wb_acks[0]), 32'd0);
    tick();
    idle_in();

    // Stray ack in START
    resp_en[0] = 0;
    stray[0] = 1;
    @(negedge CLK);
    check("stray_outs", 32'(act0), 32'd0);
    tick();
    stray[0] = 0;
    @(negedge CLK);
    check("stray_after", 32'(act0), 32'd0);
    tick();

    // Write-through write hit, 5-cycle ack delay
    clear_mon();
    resp_en[1] = 1; delay[1] = 5;
    wr[1] = 1; ht[1] = 1;
    @(negedge CLK);
    check("wthit_start", 32'({act1[9], act1[8], act1[5]}), 32'h6);
    tick();
    wr[1] = 0; ht[1] = 0;
    wait_idle(1);
    check("wthit_stall_cycles", 32'(mw_stall), 32'd5);
    check("wthit_ack_nostall", 32'(mw_ack), 32'd1);
    check("wthit_no_dirty", 32'(sd_cnt1), 32'd0);

    // Write-through write miss: no allocate
    clear_mon();
    wr[1] = 1; ht[1] = 0; dt[1] = 1;
    @(negedge CLK);
    check("wtmiss_start", 32'({act1[9], act1[8]}), 32'h2);
    tick();
    idle_in();
    wait_idle(1);
    check("wtmiss_no_fill", 32'(fill_cnt[1]), 32'd0);
    check("wtmiss_mem_write", 32'(mw_ack), 32'd1);

    // Write-through dirty read miss: never writes back
    clear_mon();
    rd[1] = 1; ht[1] = 0; dt[1] = 1;
    tick();
    ht[1] = 1;
    wait_idle(1);
    @(negedge CLK);
    check("wtrd_no_wb", 32'(wb_acks[1]), 32'd0);
    check("wtrd_fill_cnt", 32'(fill_cnt[1]), 32'd4);
    check("wtrd_rehit", 32'(act1[9]), 32'd0);
    tick();
    idle_in();
    tick();

    // Reset in the middle of a refill at word 2
    clear_mon();
    resp_en[0] = 1; delay[0] = 3;
    rd[0] = 1; ht[0] = 0; dt[0] = 0;
    tick();
    ht[0] = 1;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (act0[1:0] == 2'd2 && act0[4] && !act0[3]) begin
        found = 1;
        break;
      end
      tick();
    end
    check("midload_reached", 32'(found), 32'd1);
    RST = 1'b0;
    idle_in();
    @(negedge CLK);
    check("midload_reset_outs", 32'(act0), 32'd0);
    tick();
    RST = 1'b1;
    repeat (5) tick();
    check("midload_no_valid", 32'(sv_cnt[0]), 32'd0);
    check("midload_idle_outs", 32'(act0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_ctrl_fsm.md
Name: dcache_ctrl_fsm

Overview:
- Parametrised successor to the data-cache controller FSM in the pipelined core; sits between the memory stage, the data-cache arrays and the main-memory port.
- Handles hit/miss/dirty decisions and multi-word line fills and write-backs over a variable-latency req/ack memory port.
- Selectable write-back/write-allocate or write-through/no-write-allocate policy.
- Drives the pipeline-wide stall.

Parameters:
WORDS_PER_BLOCK, 4, words per cache line; power of two, >=2
WRITE_THROUGH, 0, 0 = write-back + write-allocate; 1 = write-through + no-write-allocate
IDX_W, $clog2(WORDS_PER_BLOCK), width of word index (derived, not overridden)

Ports:
CLK  in  1  single clock
RST  in  1  reset: one clock; reset is asynchronous and active-low
read  in  1  memory-stage load request
write  in  1  memory-stage store request
hit  in  1  tag match and valid, from cache arrays (combinational)
dirty  in  1  victim line dirty bit
mem_ack  in  1  memory accepted/returned one word this cycle
stall  out  1  freeze pipeline
cache_we  out  1  store word from CPU into cache
fill_we  out  1  write memory word into cache at word_idx
set_valid  out  1  mark line valid, clear dirty (refill complete)
set_dirty  out  1  mark line dirty
mem_req  out  1  memory transaction request
mem_we  out  1  1 = memory write, 0 = memory read
addr_sel  out  1  1 = victim tag address, 0 = CPU address
word_idx  out  IDX_W  current burst word

Behaviour:
- States: START, WRITE_BACK, LOAD, REFILL_DONE, MEM_WRITE. Moore/Mealy mix: outputs combinational from state and inputs; state and word_idx registered.
- Reset (RST=0, async): state=START, word_idx=0. With read=write=0 every output is 0.
- read and write both high: read has priority.
- START, read&&hit: stall=0, zero-cycle hit, stay.
- START, write&&hit, WB mode: cache_we=1, set_dirty=1, stall=0, stay.
- START, write&&hit, WT mode: cache_we=1, stall=1, go MEM_WRITE.
- START, miss (read, or write in WB mode): stall=1.
  - dirty && !WRITE_THROUGH: go WRITE_BACK.
  - Otherwise: go LOAD.
  - word_idx=0 on entry.
- START, write miss in WT mode: stall=1, go MEM_WRITE; no allocate.
- WRITE_BACK: mem_req=1, mem_we=1, addr_sel=1, stall=1.
  - On mem_ack: word_idx++.
  - On mem_ack at word_idx==WORDS_PER_BLOCK-1: word_idx wraps to 0, go LOAD.
- LOAD: mem_req=1, mem_we=0, addr_sel=0, stall=1.
  - fill_we=mem_ack.
  - On mem_ack: word_idx++.
  - On mem_ack at the last word: wrap to 0, go REFILL_DONE.
- REFILL_DONE: set_valid=1, stall=1, go START. The re-lookup in START then hits and completes; a write-allocate store performs cache_we/set_dirty there.
- MEM_WRITE: mem_req=1, mem_we=1, addr_sel=0, single word.
  - stall=1 until mem_ack; stall=0 in the mem_ack cycle (pipeline advances at that edge), then go START.
- mem_ack while mem_req=0: ignored. mem_req held high and stable until mem_ack; no per-word timeout.
- word_idx changes only on mem_ack in WRITE_BACK/LOAD, or on reset/entry. Never exceeds WORDS_PER_BLOCK-1.
- Reset mid-burst: immediate return to START, mem_req drops, partial line not marked valid (set_valid never asserted). Memory side tolerates the abandoned transaction.
- hit/dirty sampled only in START; changes in other states have no effect.

Decomposition:
- Package dcache_pkg: state enum (START, WRITE_BACK, LOAD, REFILL_DONE, MEM_WRITE), policy constants POLICY_WB=0 / POLICY_WT=1.
- One sub-module dcache_word_ctr: IDX_W-bit counter with clear, increment-on-ack and last-word flag. Async active-low reset on CLK/RST.

Test Plan:
1. Reset: RST=0 mid-LOAD at word_idx=2 -> next sample state START, word_idx=0, mem_req=0, stall=0, set_valid never pulsed.
2. Read hit, WB, WORDS_PER_BLOCK=4: read=1, hit=1 -> stall=0 same cycle, no mem_req, state stays START.
3. Read miss clean: read=1, hit=0, dirty=0, mem_ack after 3-cycle delay per word:
   - LOAD issues 4 acks; fill_we pulses with word_idx 0,1,2,3.
   - set_valid pulses once in REFILL_DONE.
   - stall high from miss cycle through REFILL_DONE; the next START cycle hits with stall=0.
4. Write miss dirty, WB:
   - WRITE_BACK with mem_we=1, addr_sel=1 for 4 acks, then LOAD with 4 acks, then REFILL_DONE.
   - Final START: cache_we=1, set_dirty=1, stall=0.
5. WT write hit: write=1, hit=1, WRITE_THROUGH=1:
   - cache_we=1 in START, then MEM_WRITE with mem_req=1, mem_we=1.
   - mem_ack held off 5 cycles -> stall=1 for those cycles, stall=0 in the ack cycle, then START; set_dirty never asserted.
6. Simultaneous read=1, write=1, hit=0 -> treated as read miss (LOAD). Stray mem_ack in START -> no state or word_idx change.
